// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encoding and op-field width.
package logic_gate_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_if.sv
// Request/response bundle between a requester and the logic gate unit.
interface logic_gate_if
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OP_W-1:0]  op;
  logic             in_valid;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             illegal_op;
  logic             y_zero;

  modport master (
    output A, B, op, in_valid,
    input  Y, out_valid, illegal_op, y_zero
  );

  modport slave (
    input  A, B, op, in_valid,
    output Y, out_valid, illegal_op, y_zero
  );

endinterface

// File: rtl/logic_gate_core.sv
// Combinational bitwise gate: selects one of seven logic functions of A and B.
// The reserved op yields a zero result and raises illegal.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  // Decode op into the selected bitwise function.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (op_e'(op))
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_NOT:  result = ~A;
      OP_XOR:  result = A ^ B;
      OP_NAND: result = ~(A & B);
      OP_NOR:  result = ~(A | B);
      OP_XNOR: result = ~(A ^ B);
      OP_RSVD: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered logic gate unit: one-cycle latency, no backpressure.
// All outputs come straight from flops; y_zero and illegal_op track Y exactly.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  logic_gate_if.slave bus
);

  logic [WIDTH-1:0] result;
  logic             illegal;

  logic_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A       (bus.A),
    .B       (bus.B),
    .op      (bus.op),
    .result  (result),
    .illegal (illegal)
  );

  // Capture accepted requests; idle edges hold the result and drop out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Y          <= '0;
      bus.out_valid  <= 1'b0;
      bus.illegal_op <= 1'b0;
      bus.y_zero     <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Y          <= result;
        bus.illegal_op <= illegal;
        bus.y_zero     <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop and compare.
module tb_logic_gate_unit;

  typedef struct {
    logic [7:0] y;
    logic       ill;
    logic       zero;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q8[$];
  exp_t q1[$];
  logic [3:0] tt[7];

  logic_gate_if #(.WIDTH(8)) bus8 ();
  logic_gate_if #(.WIDTH(1)) bus1 ();

  logic_gate_unit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  logic_gate_unit #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // Drive one WIDTH=8 request for one cycle and queue its expected response.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] y, input logic ill, input logic zero);
    exp_t e;
    bus8.A = a; bus8.B = b; bus8.op = op; bus8.in_valid = 1'b1;
    e.y = y; e.ill = ill; e.zero = zero; e.cyc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic issue1(input logic a, input logic b, input logic [2:0] op, input logic y);
    exp_t e;
    bus1.A = a; bus1.B = b; bus1.op = op; bus1.in_valid = 1'b1;
    e.y = {7'd0, y}; e.ill = 1'b0; e.zero = ~y; e.cyc = cyc + 1;
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  // Idle cycles on the 8-bit unit, checking the previous result is held.
  task automatic idle8(input int n, input logic [7:0] y_held);
    bus8.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("hold_y", 32'(bus8.Y), 32'(y_held));
      check("hold_out_valid", 32'(bus8.out_valid), 32'd0);
    end
  endtask

  // Monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (bus8.out_valid === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result8 got Y=%h with no request pending", bus8.Y);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (bus8.Y !== e.y || bus8.illegal_op !== e.ill || bus8.y_zero !== e.zero
            || cyc != e.cyc) begin
          errors++;
          $display("FAIL result8 got Y=%h ill=%b zero=%b cyc=%0d required Y=%h ill=%b zero=%b cyc=%0d",
                   bus8.Y, bus8.illegal_op, bus8.y_zero, cyc, e.y, e.ill, e.zero, e.cyc);
        end
      end
    end
  end

  // Monitor for the 1-bit unit.
  always @(negedge clk) begin
    if (bus1.out_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result1 got Y=%b with no request pending", bus1.Y);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (bus1.Y !== e.y[0] || bus1.illegal_op !== e.ill || bus1.y_zero !== e.zero
            || cyc != e.cyc) begin
          errors++;
          $display("FAIL result1 got Y=%b ill=%b zero=%b cyc=%0d required Y=%b ill=%b zero=%b cyc=%0d",
                   bus1.Y, bus1.illegal_op, bus1.y_zero, cyc, e.y[0], e.ill, e.zero, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] ya [7];
    logic [7:0] ra, rb, ry;
    logic [2:0] rop;
    checks = 0;
    errors = 0;
    // Truth tables indexed by {a,b}: AND OR NOT XOR NAND NOR XNOR.
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001;
    ya[0] = 8'hC0; ya[1] = 8'hFC; ya[2] = 8'h0F; ya[3] = 8'h3C;
    ya[4] = 8'h3F; ya[5] = 8'h03; ya[6] = 8'hC3;

    bus8.A = '0; bus8.B = '0; bus8.op = '0; bus8.in_valid = 1'b0;
    bus1.A = '0; bus1.B = '0; bus1.op = '0; bus1.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_y", 32'(bus8.Y), 32'd0);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_illegal", 32'(bus8.illegal_op), 32'd0);
    check("rst_y_zero", 32'(bus8.y_zero), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First request lands on the first edge after reset release.
    for (int i = 0; i < 7; i++) issue8(8'hF0, 8'hCC, 3'(i), ya[i], 1'b0, 1'b0);
    issue8(8'hFF, 8'h00, 3'd7, 8'h00, 1'b1, 1'b1);
    issue8(8'hAA, 8'h55, 3'd0, 8'h00, 1'b0, 1'b1);
    idle8(3, 8'h00);
    issue8(8'hF0, 8'hCC, 3'd3, 8'h3C, 1'b0, 1'b0);
    idle8(1, 8'h3C);

    // WIDTH=1 truth tables.
    for (int op = 0; op < 7; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [3:0] row;
        logic [1:0] idx;
        row = tt[op];
        idx = 2'(ab);
        issue1(idx[1], idx[0], 3'(op), row[idx]);
      end
    end
    bus1.in_valid = 1'b0;

    // Reset between edges while Y=FF; the request pending at that edge is dropped.
    issue8(8'hFF, 8'h00, 3'd1, 8'hFF, 1'b0, 1'b0);
    bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.op = 3'd0; bus8.in_valid = 1'b1;
    #6;
    rst = 1'b1;
    #1;
    check("midrst_y", 32'(bus8.Y), 32'd0);
    check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrst_y_zero", 32'(bus8.y_zero), 32'd1);
    check("midrst_illegal", 32'(bus8.illegal_op), 32'd0);
    @(posedge clk); #1;
    check("rst_edge_out_valid", 32'(bus8.out_valid), 32'd0);
    rst = 1'b0;
    idle8(2, 8'h00);

    // Back-to-back random stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = 3'($urandom_range(0, 7));
      ry = model(ra, rb, rop);
      issue8(ra, rb, rop, ry, (rop == 3'd7), (ry == 8'h00));
    end
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B; ignored for NOT.
REQ-006 op  input  3  operation select: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 reserved.
REQ-007 in_valid  input  1  A, B and op are sampled on a rising edge when high.
REQ-008 Y  output  WIDTH  registered result.
REQ-009 out_valid  output  1  Y holds the result of the request accepted on the previous edge.
REQ-010 illegal_op  output  1  registered flag: the accepted op was 7.
REQ-011 y_zero  output  1  registered flag: the accepted result is all zeros.

Function
REQ-012 Bitwise results per bit i: AND A&B; OR A|B; NOT ~A; XOR A^B; NAND ~(A&B); NOR ~(A|B); XNOR ~(A^B).
REQ-013 Latency is exactly one clock: the request sampled at edge N appears on Y, illegal_op and y_zero after edge N, with out_valid=1.
REQ-014 When in_valid=1 and op=7, Y=0, illegal_op=1, y_zero=1, and out_valid=1.
REQ-015 When in_valid=0 at an edge, Y, illegal_op and y_zero hold their previous values, and out_valid=0.
REQ-016 There is no backpressure: a new request can be accepted on every edge, and back-to-back requests produce back-to-back results.
REQ-017 illegal_op and y_zero are computed from the same accepted request as Y and are never stale relative to Y.
REQ-018 Inputs that change between edges have no effect on the outputs; all outputs are driven directly from flops.
REQ-019 The result is exactly WIDTH bits wide, with no extension or truncation.

Reset
REQ-020 While rst=1, Y=0, out_valid=0, illegal_op=0 and y_zero=1, applied immediately without waiting for a clock edge.
REQ-021 Asserting rst mid-stream discards any request sampled on that edge.
REQ-022 The first request is accepted on the first rising edge after rst deasserts.

Structure
REQ-023 A shared package logic_gate_pkg holds the op encoding enum (OP_AND..OP_XNOR, OP_RSVD) and the op-width constant.
REQ-024 One combinational sub-module, logic_gate_core (A, B, op -> result, illegal), implements REQ-012 and REQ-014.
REQ-025 logic_gate_unit instantiates logic_gate_core and adds only the output registers and the y_zero computation.

Verification
REQ-026 WIDTH=8: set A=8'hF0, B=8'hCC and sweep op 0..6 on consecutive edges with in_valid=1. Required Y sequence: C0, FC, 0F, 3C, 3F, 03, C3, with out_valid=1 every cycle.
REQ-027 WIDTH=1: apply all four (A,B) pairs for each of ops 0..6. Y matches the standard two-input truth table, and NOT gives Y=~A regardless of B.
REQ-028 op=7 with A=8'hFF, B=8'h00: required Y=00, illegal_op=1, y_zero=1.
REQ-029 A=8'hAA, B=8'h55, op=AND: required Y=00 and y_zero=1. Then deassert in_valid for 3 cycles: required Y=00 held and out_valid=0.
REQ-030 Assert rst between clock edges while Y=8'hFF: required Y=00, out_valid=0 and y_zero=1 before the next edge, and no result emitted for the discarded request.
REQ-031 Randomized back-to-back stream of 1000 requests checked against a reference model: zero mismatches, with one-cycle latency on every result.
